// File: rtl/bus_uart.sv
// bus_uart: memory-mapped 8N1 UART bus responder with a TX FIFO and a single-byte RX holding register.
// bus_done has variable latency: a DATA write to a full TX FIFO is held in WAIT_TX until a slot frees.
module bus_uart #(
    parameter int CLK_DIV       = 434,
    parameter int TX_FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wmask,
    input  logic        bus_ren,
    input  logic        bus_wen,
    output logic [31:0] bus_rdata,
    output logic        bus_done,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        irq
);
    localparam int AW    = $clog2(TX_FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    typedef enum logic [1:0] {IDLE, RESP, WAIT_TX} bus_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    bus_state_t       state;
    logic [15:0]      div_reg;
    logic [15:0]      period;
    logic [15:0]      half_m1;

    logic [7:0]       fifo_mem [TX_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_push;
    logic             fifo_pop;

    logic             tx_busy;
    logic [3:0]       tx_bits;
    logic [15:0]      tx_cnt;
    logic [8:0]       tx_data;
    logic             tx_ready;
    logic             tx_idle;

    logic             rx_s1;
    logic             rx_s2;
    logic             rx_s3;
    rx_state_t        rx_state;
    logic [15:0]      rx_cnt;
    logic [2:0]       rx_bits;
    logic [7:0]       rx_shift;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_overrun;
    logic             rx_stop_hit;

    logic [1:0]       sel;
    logic             req;
    logic             accept_slot;
    logic             data_push_req;
    logic             stall;
    logic             do_acc;
    logic             rd_clr;
    logic             ovr_clr;
    logic             div_we;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    assign unused_bits = ^{bus_addr[31:4], bus_addr[1:0], bus_wdata[31:16], bus_wmask[3:2]};

    // The effective bit period never drops below 16 cycles.
    assign period  = (div_reg < 16'd16) ? 16'd16 : div_reg;
    assign half_m1 = {1'b0, period[15:1]} - 16'd1;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign sel           = bus_addr[3:2];
    assign req           = bus_ren | bus_wen;
    assign accept_slot   = (state != WAIT_TX) && req;
    assign data_push_req = bus_wen && (sel == 2'd0) && bus_wmask[0];
    assign stall         = accept_slot && data_push_req && fifo_full;
    assign do_acc        = accept_slot && !stall;
    assign fifo_push     = (do_acc && data_push_req) || ((state == WAIT_TX) && !fifo_full);
    assign rd_clr        = do_acc && !bus_wen && (sel == 2'd0);
    assign ovr_clr       = do_acc && bus_wen && (sel == 2'd1) && bus_wmask[0] && bus_wdata[3];
    assign div_we        = do_acc && bus_wen && (sel == 2'd2);

    assign tx_ready = !tx_busy || ((tx_cnt == 16'd0) && (tx_bits == 4'd0));
    assign fifo_pop = tx_ready && !fifo_empty;
    assign tx_idle  = fifo_empty && !tx_busy;

    assign rx_stop_hit = (rx_state == RX_STOP) && (rx_cnt == 16'd0);
    assign irq         = rx_valid;

    always_comb begin
        rd_mux = 32'd0;
        case (sel)
            2'd0:    rd_mux = {24'd0, rx_byte};
            2'd1:    rd_mux = {28'd0, rx_overrun, rx_valid, fifo_full, tx_idle};
            2'd2:    rd_mux = {16'd0, div_reg};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bus_done  <= 1'b0;
            bus_rdata <= 32'd0;
        end else begin
            bus_done  <= 1'b0;
            bus_rdata <= 32'd0;
            case (state)
                IDLE, RESP: begin
                    if (stall) begin
                        state <= WAIT_TX;
                    end else if (req) begin
                        state    <= RESP;
                        bus_done <= 1'b1;
                        if (!bus_wen) bus_rdata <= rd_mux;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_TX: begin
                    if (!fifo_full) begin
                        state    <= RESP;
                        bus_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= 16'(CLK_DIV);
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (div_we && bus_wmask[0]) div_reg[7:0]  <= bus_wdata[7:0];
            if (div_we && bus_wmask[1]) div_reg[15:8] <= bus_wdata[15:8];
            if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr[AW-1:0]] <= bus_wdata[7:0];
    end

    // TX: a pop at the end of a stop bit loads the next start bit with no idle gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy <= 1'b0;
            tx_bits <= 4'd0;
            tx_cnt  <= 16'd0;
            uart_tx <= 1'b1;
        end else if (fifo_pop) begin
            tx_busy <= 1'b1;
            tx_bits <= 4'd9;
            tx_cnt  <= period - 16'd1;
            uart_tx <= 1'b0;
        end else if (tx_busy) begin
            if (tx_cnt != 16'd0) begin
                tx_cnt <= tx_cnt - 16'd1;
            end else if (tx_bits == 4'd0) begin
                tx_busy <= 1'b0;
            end else begin
                uart_tx <= tx_data[0];
                tx_bits <= tx_bits - 4'd1;
                tx_cnt  <= period - 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_pop)
            tx_data <= {1'b1, fifo_mem[rd_ptr[AW-1:0]]};
        else if (tx_busy && (tx_cnt == 16'd0) && (tx_bits != 4'd0))
            tx_data <= {1'b1, tx_data[8:1]};
    end

    // RX: synchronizer, start-bit qualification at half period, then centre sampling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_s3      <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= 16'd0;
            rx_bits    <= 3'd0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_s3 && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= half_m1;
                    end
                end
                RX_START: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else if (rx_s2) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_state <= RX_DATA;
                        rx_cnt   <= period - 16'd1;
                        rx_bits  <= 3'd0;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else begin
                        rx_cnt  <= period - 16'd1;
                        rx_bits <= rx_bits + 3'd1;
                        if (rx_bits == 3'd7) rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
                    else                 rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
            // Later assignments win: a new byte overrides a same-edge read clear.
            if (ovr_clr) rx_overrun <= 1'b0;
            if (rd_clr)  rx_valid   <= 1'b0;
            if (rx_stop_hit) begin
                rx_valid <= 1'b1;
                if (rx_valid) rx_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((rx_state == RX_DATA) && (rx_cnt == 16'd0)) rx_shift <= {rx_s2, rx_shift[7:1]};
        if (rx_stop_hit) rx_byte <= rx_shift;
    end

endmodule

// File: tb/tb_bus_uart.sv
// tb_bus_uart: directed bench for bus_uart covering reset, TX framing, FIFO stall, RX/overrun, glitch and reset abort.
// A background line monitor decodes uart_tx frames at 16 cycles per bit into a byte queue.
module tb_bus_uart;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_ren;
    logic        bus_wen;
    logic [31:0] bus_rdata;
    logic        bus_done;
    logic        uart_tx;
    logic        uart_rx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] mon_q[$];
    int         mon_ferr = 0;

    bus_uart #(.CLK_DIV(434), .TX_FIFO_DEPTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wmask (bus_wmask),
        .bus_ren   (bus_ren),
        .bus_wen   (bus_wen),
        .bus_rdata (bus_rdata),
        .bus_done  (bus_done),
        .uart_tx   (uart_tx),
        .uart_rx   (uart_rx),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin : tx_monitor
        int         cnt;
        int         bitn;
        logic [9:0] sh;
        logic       busy;
        busy = 1'b0;
        cnt  = 0;
        bitn = 0;
        sh   = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                busy = 1'b0;
            end else if (!busy) begin
                if (uart_tx === 1'b0) begin
                    busy = 1'b1;
                    cnt  = 0;
                    bitn = 0;
                end
            end else begin
                cnt++;
                if (cnt == 16 * bitn + 8) begin
                    sh[bitn] = uart_tx;
                    bitn++;
                    if (bitn == 10) begin
                        mon_q.push_back(sh[8:1]);
                        if (sh[0] !== 1'b0 || sh[9] !== 1'b1) mon_ferr++;
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output int lat);
        @(negedge clk);
        bus_addr = a;
        bus_ren  = 1'b1;
        lat      = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus_done !== 1'b1 && lat < 400);
        d       = bus_rdata;
        bus_ren = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m, output int lat);
        @(negedge clk);
        bus_addr  = a;
        bus_wdata = wd;
        bus_wmask = m;
        bus_wen   = 1'b1;
        lat       = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (bus_done !== 1'b1 && lat < 400);
        bus_wen = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output int vlat);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            uart_rx = fr[k];
            repeat (15) @(negedge clk);
        end
        @(negedge clk);
        uart_rx = fr[9];
        repeat (8) @(negedge clk);
        vlat = 0;
        do begin
            @(posedge clk);
            #1;
            vlat++;
        end while (irq !== 1'b1 && vlat < 6);
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int          lat;
        rst_n     = 1'b0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        bus_wmask = 4'h0;
        bus_ren   = 1'b0;
        bus_wen   = 1'b0;
        uart_rx   = 1'b1;
        repeat (3) @(negedge clk);
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", uart_tx); end
        checks++;
        if (bus_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus_done); end
        checks++;
        if (bus_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus_rdata); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        checks++;
        rst_n = 1'b1;
        bus_read(32'h4, d, lat);
        if (lat !== 1) begin errors++; $display("FAIL status_lat: got %0d expected 1", lat); end
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL reset_status: got %h expected 1", d); end
        checks++;
        @(posedge clk);
        #1;
        if (bus_done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", bus_done); end
        checks++;
        if (bus_rdata !== 32'd0) begin errors++; $display("FAIL rdata_idle: got %h expected 0", bus_rdata); end
        checks++;
        bus_read(32'h8, d, lat);
        if (d !== 32'd434) begin errors++; $display("FAIL reset_div: got %0d expected 434", d); end
        checks++;
    endtask

    task automatic test_single_tx();
        logic [31:0]  d;
        int           lat;
        int           off;
        logic [9:0]   exp_bits;
        logic [159:0] trace;
        logic [15:0]  seg;
        exp_bits = 10'b1101001010;
        bus_write(32'h8, 32'd16, 4'h3, lat);
        bus_read(32'h8, d, lat);
        if (d !== 32'd16) begin errors++; $display("FAIL div_write: got %0d expected 16", d); end
        checks++;
        bus_write(32'h0, 32'hA5, 4'h1, lat);
        if (lat !== 1) begin errors++; $display("FAIL tx_write_lat: got %0d expected 1", lat); end
        checks++;
        off = 0;
        while (uart_tx !== 1'b0 && off < 3) begin
            @(posedge clk);
            #1;
            off++;
        end
        if (off > 1) begin errors++; $display("FAIL tx_start_delay: got %0d expected <=1", off); end
        checks++;
        for (int c = 0; c < 160; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            trace[c] = uart_tx;
        end
        for (int k = 0; k < 10; k++) begin
            seg = trace[16*k +: 16];
            if (seg !== {16{exp_bits[k]}}) begin
                errors++;
                $display("FAIL tx_bit%0d: got %h expected %h", k, seg, {16{exp_bits[k]}});
            end
            checks++;
        end
        repeat (3) @(posedge clk);
        bus_read(32'h4, d, lat);
        if (d !== 32'h1) begin errors++; $display("FAIL tx_done_status: got %h expected 1", d); end
        checks++;
        if (mon_q.size() != 1 || mon_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL tx_monitor_byte: got %0d bytes expected one A5", mon_q.size());
        end
        checks++;
    endtask

    task automatic test_fifo_full();
        logic [31:0] d;
        int          lat;
        int          cyc;
        int          f0;
        logic [7:0]  got;
        mon_q.delete();
        f0 = mon_ferr;
        @(negedge clk);
        bus_addr  = 32'h0;
        bus_wmask = 4'h1;
        bus_wdata = 32'h10;
        bus_wen   = 1'b1;
        for (int i = 0; i < 17; i++) begin
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
            end while (bus_done !== 1'b1 && lat < 400);
            if (lat !== 1) begin errors++; $display("FAIL b2b_lat%0d: got %0d expected 1", i, lat); end
            checks++;
            if (i < 16) bus_wdata = 32'h10 + 32'(i + 1);
            else        bus_wen   = 1'b0;
        end
        bus_read(32'h4, d, lat);
        if (d !== 32'h2) begin errors++; $display("FAIL full_status: got %h expected 2", d); end
        checks++;
        bus_write(32'h0, 32'h21, 4'h1, lat);
        if (lat < 140 || lat > 150) begin errors++; $display("FAIL stall_lat: got %0d expected 140..150", lat); end
        checks++;
        cyc = 0;
        while (mon_q.size() < 18 && cyc < 3500) begin
            @(posedge clk);
            cyc++;
        end
        if (mon_q.size() != 18) begin errors++; $display("FAIL fifo_count: got %0d expected 18", mon_q.size()); end
        checks++;
        for (int i = 0; i < 18; i++) begin
            got = (i < mon_q.size()) ? mon_q[i] : 8'hxx;
            if (got !== 8'(8'h10 + i)) begin
                errors++;
                $display("FAIL fifo_byte%0d: got %h expected %h", i, got, 8'(8'h10 + i));
            end
            checks++;
        end
        if (mon_ferr != f0) begin errors++; $display("FAIL frame_bits: got %0d bad frames expected 0", mon_ferr - f0); end
        checks++;
    endtask

    task automatic test_rx_overrun();
        logic [31:0] d;
        int          lat;
        int          vlat;
        send_byte(8'h3C, vlat);
        if (vlat > 3) begin errors++; $display("FAIL rx_valid_lat: got %0d expected <=3", vlat); end
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq: got %b expected 1", irq); end
        checks++;
        bus_read(32'h0, d, lat);
        if (d !== 32'h3C) begin errors++; $display("FAIL rx_data: got %h expected 3c", d); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rx_clear: got %b expected 0", irq); end
        checks++;
        send_byte(8'h11, vlat);
        send_byte(8'h22, vlat);
        bus_read(32'h4, d, lat);
        if (d !== 32'hD) begin errors++; $display("FAIL overrun_status: got %h expected d", d); end
        checks++;
        bus_read(32'h0, d, lat);
        if (d !== 32'h22) begin errors++; $display("FAIL overrun_data: got %h expected 22", d); end
        checks++;
        bus_write(32'h4, 32'h8, 4'h1, lat);
        bus_read(32'h4, d, lat);
        if (d !== 32'h1) begin errors++; $display("FAIL overrun_clear: got %h expected 1", d); end
        checks++;
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        int          lat;
        int          vlat;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b expected 0", irq); end
        checks++;
        bus_read(32'h4, d, lat);
        if (d !== 32'h1) begin errors++; $display("FAIL glitch_status: got %h expected 1", d); end
        checks++;
        send_byte(8'h5A, vlat);
        bus_read(32'h0, d, lat);
        if (d !== 32'h5A) begin errors++; $display("FAIL post_glitch_rx: got %h expected 5a", d); end
        checks++;
    endtask

    task automatic test_reset_mid_tx();
        logic [31:0] d;
        int          lat;
        int          lows;
        for (int i = 0; i < 3; i++) begin
            bus_write(32'h0, 32'h00, 4'h1, lat);
            if (lat !== 1) begin errors++; $display("FAIL q_write%0d: got %0d expected 1", i, lat); end
            checks++;
        end
        repeat (40) @(posedge clk);
        #1;
        if (uart_tx !== 1'b0) begin errors++; $display("FAIL mid_frame_low: got %b expected 0", uart_tx); end
        checks++;
        #2;
        rst_n = 1'b0;
        #1;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL async_tx_high: got %b expected 1", uart_tx); end
        checks++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (uart_tx !== 1'b1) lows++;
        end
        if (lows !== 0) begin errors++; $display("FAIL residual_bits: got %0d low cycles expected 0", lows); end
        checks++;
        bus_read(32'h4, d, lat);
        if (d !== 32'h1) begin errors++; $display("FAIL post_reset_status: got %h expected 1", d); end
        checks++;
        bus_read(32'h8, d, lat);
        if (d !== 32'd434) begin errors++; $display("FAIL post_reset_div: got %0d expected 434", d); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_fifo_full();
        test_rx_overrun();
        test_glitch();
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
